// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, write-buffer FSM states and entry layout for the L2/memory path.
package cache_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} wb_state_t;
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_entry_store.sv
// wb_entry_store: circular FIFO of posted writes with parallel youngest-match lookup.
// WB_MERGE_EN adds in-place merging of pushes that hit a valid, unlocked entry.
module wb_entry_store import cache_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [ADDR_W-1:0]       pushAddr,
  input  logic [DATA_W-1:0]       pushData,
  input  logic [ADDR_W-1:0]       lookupAddr,
`ifdef WB_MERGE_EN
  input  logic                    headLocked,
  output logic                    mergeHit,
`endif
  output logic [ADDR_W-1:0]       headAddr,
  output logic [DATA_W-1:0]       headData,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    hit,
  output logic [DATA_W-1:0]       hitData
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] head, tail, hitIdx;
  logic alloc;
  assign full = count == (PW+1)'(DEPTH);
  assign headAddr = mem[head].addr;
  assign headData = mem[head].data;
  assign hitData = mem[hitIdx].data;
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit = 1'b0;
    hitIdx = head;
    for (int i = 0; i < DEPTH; i++)
      if (mem[head + PW'(i)].valid && mem[head + PW'(i)].addr == lookupAddr) begin
        hit = 1'b1;
        hitIdx = head + PW'(i);
      end
  end
`ifdef WB_MERGE_EN
  logic [PW-1:0] mergeIdx;
  // The head entry is frozen once it is (or is about to be) on the memory port.
  always_comb begin
    mergeHit = 1'b0;
    mergeIdx = head;
    for (int i = 0; i < DEPTH; i++)
      if (mem[head + PW'(i)].valid && mem[head + PW'(i)].addr == pushAddr &&
          !(headLocked && i == 0)) begin
        mergeHit = 1'b1;
        mergeIdx = head + PW'(i);
      end
  end
  assign alloc = push && !mergeHit;
`else
  assign alloc = push;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (alloc) begin
        mem[tail] <= '{valid: 1'b1, addr: pushAddr, data: pushData};
        tail <= tail + 1'b1;
      end
`ifdef WB_MERGE_EN
      if (push && mergeHit) mem[mergeIdx].data <= pushData;
`endif
      if (pop) begin
        mem[head].valid <= 1'b0;
        head <= head + 1'b1;
      end
      count <= count + (PW+1)'(alloc) - (PW+1)'(pop);
    end
endmodule

// File: rtl/l2_mem_write_buffer.sv
// l2_mem_write_buffer: posted L2 eviction buffer with read forwarding and read-first memory arbitration.
// Optional WB_MERGE_EN merges pushes into matching queued entries.
module l2_mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l2_we,
  input  logic              l2_re,
  input  logic [ADDR_W-1:0] l2_addr,
  input  logic [DATA_W-1:0] l2_wdata,
  output logic              l2_stall,
  output logic [DATA_W-1:0] l2_rdata,
  output logic              l2_rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stb
);
  import cache_pkg::*;
  wb_state_t state;
  logic rdPending, rdOk, push, pop, full, hit;
  logic [ADDR_W-1:0] rdAddr, headAddr;
  logic [DATA_W-1:0] headData, hitData;
  logic [$clog2(DEPTH):0] count;
  assign l2_stall = full || rdPending;
  assign rdOk = l2_re && !l2_stall;
  assign pop = state == WR_BUSY && mem_stb;
`ifdef WB_MERGE_EN
  logic mergeHit, headLocked;
  assign headLocked = state == WR_BUSY || (state == IDLE && !rdPending && count != '0);
  assign push = l2_we && !rdPending && (!full || mergeHit);
`else
  assign push = l2_we && !l2_stall;
`endif
  wb_entry_store #(.DEPTH(DEPTH)) store (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .pushAddr(l2_addr),
    .pushData(l2_wdata),
    .lookupAddr(l2_addr),
`ifdef WB_MERGE_EN
    .headLocked(headLocked),
    .mergeHit(mergeHit),
`endif
    .headAddr(headAddr),
    .headData(headData),
    .count(count),
    .full(full),
    .hit(hit),
    .hitData(hitData)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rdPending <= 1'b0;
      rdAddr <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      l2_rdata <= '0;
      l2_rvalid <= 1'b0;
    end else begin
      l2_rvalid <= 1'b0;
      if (rdOk) begin
        rdAddr <= l2_addr;
        if (hit) begin
          l2_rdata <= hitData;
          l2_rvalid <= 1'b1;
        end else rdPending <= 1'b1;
      end
      case (state)
        IDLE:
          if (rdPending) begin
            state <= RD_BUSY;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= rdAddr;
          end else if (count != '0) begin
            state <= WR_BUSY;
            mem_req <= 1'b1;
            mem_we <= 1'b1;
            mem_addr <= headAddr;
            mem_wdata <= headData;
          end
        WR_BUSY:
          if (mem_stb) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
          end
        RD_BUSY:
          if (mem_stb) begin
            state <= IDLE;
            mem_req <= 1'b0;
            rdPending <= 1'b0;
            l2_rdata <= mem_rdata;
            l2_rvalid <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// tb_l2_mem_write_buffer: directed self-checking bench for the posted write buffer.
module tb_l2_mem_write_buffer;
  logic clk = 1'b0, rst_n = 1'b0, l2_we = 1'b0, l2_re = 1'b0, mem_stb = 1'b0;
  logic [31:0] l2_addr = '0;
  logic [63:0] l2_wdata = '0, mem_rdata = '0;
  logic l2_stall, l2_rvalid, mem_req, mem_we;
  logic [63:0] l2_rdata, mem_wdata;
  logic [31:0] mem_addr;
  int errors = 0, checks = 0, sent = 0;
  logic [31:0] wrAddrQ[$];
  logic [63:0] wrDataQ[$];

  always #5 clk = ~clk;

  l2_mem_write_buffer dut (
    .clk(clk), .rst_n(rst_n), .l2_we(l2_we), .l2_re(l2_re), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_stall(l2_stall), .l2_rdata(l2_rdata), .l2_rvalid(l2_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stb(mem_stb)
  );

  always @(posedge clk)
    if (mem_stb && mem_req && mem_we) begin
      wrAddrQ.push_back(mem_addr);
      wrDataQ.push_back(mem_wdata);
    end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [63:0] d);
    l2_we = 1'b1; l2_addr = a; l2_wdata = d;
    tick();
    l2_we = 1'b0;
  endtask

  task automatic serveWrite(input string tag, input logic [31:0] a, input logic [63:0] d);
    int n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    chk({tag, "_req"}, 64'(mem_req), 64'd1);
    chk({tag, "_we"}, 64'(mem_we), 64'd1);
    chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
    chk({tag, "_data"}, mem_wdata, d);
    mem_stb = 1'b1;
    tick();
    mem_stb = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_stall", 64'(l2_stall), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_rvalid", 64'(l2_rvalid), 64'd0);
    chk("rst_count", 64'(dut.store.count), 64'd0);
    rst_n = 1'b1;
    tick();
    // single write drained after a 3-cycle memory latency
    push(32'h100, 64'h11);
    tick();
    chk("t1_req", 64'(mem_req), 64'd1);
    chk("t1_we", 64'(mem_we), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h100);
    chk("t1_data", mem_wdata, 64'h11);
    tick(2);
    chk("t1_hold", 64'(mem_addr), 64'h100);
    mem_stb = 1'b1;
    tick();
    mem_stb = 1'b0;
    chk("t1_req_drop", 64'(mem_req), 64'd0);
    chk("t1_count", 64'(dut.store.count), 64'd0);
    // fill to DEPTH, reject a fifth push
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i), 64'hA0 + 64'(i));
    chk("t2_stall", 64'(l2_stall), 64'd1);
    chk("t2_count4", 64'(dut.store.count), 64'd4);
    push(32'h14, 64'hA4);
    chk("t2_reject", 64'(dut.store.count), 64'd4);
    chk("t2_head", 64'(mem_addr), 64'h10);
    mem_stb = 1'b1;
    tick();
    mem_stb = 1'b0;
    chk("t2_unstall", 64'(l2_stall), 64'd0);
    chk("t2_count3", 64'(dut.store.count), 64'd3);
    for (int i = 1; i < 4; i++) serveWrite("t2_drain", 32'h10 + 32'(i), 64'hA0 + 64'(i));
    chk("t2_empty", 64'(dut.store.count), 64'd0);
    // forwarding from the youngest duplicate while 0x250 occupies the memory port
    push(32'h250, 64'h25);
    push(32'h200, 64'hAA);
    push(32'h200, 64'hBB);
`ifdef WB_MERGE_EN
    chk("t3_count", 64'(dut.store.count), 64'd2);
`else
    chk("t3_count", 64'(dut.store.count), 64'd3);
`endif
    l2_re = 1'b1; l2_addr = 32'h200;
    tick();
    l2_re = 1'b0;
    chk("t3_rvalid", 64'(l2_rvalid), 64'd1);
    chk("t3_rdata", l2_rdata, 64'hBB);
    chk("t3_no_memrd", 64'(mem_we), 64'd1);
    tick();
    chk("t3_pulse", 64'(l2_rvalid), 64'd0);
    serveWrite("t3_w0", 32'h250, 64'h25);
`ifndef WB_MERGE_EN
    serveWrite("t3_w1", 32'h200, 64'hAA);
`endif
    serveWrite("t3_w2", 32'h200, 64'hBB);
    // read miss during WR_BUSY goes ahead of the second queued write
    push(32'h400, 64'h1);
    push(32'h404, 64'h2);
    l2_re = 1'b1; l2_addr = 32'h300;
    tick();
    l2_re = 1'b0;
    chk("t4_stall", 64'(l2_stall), 64'd1);
    chk("t4_wr_addr", 64'(mem_addr), 64'h400);
    mem_stb = 1'b1;
    tick();
    mem_stb = 1'b0;
    chk("t4_gap", 64'(mem_req), 64'd0);
    tick();
    chk("t4_rd_req", 64'(mem_req), 64'd1);
    chk("t4_rd_we", 64'(mem_we), 64'd0);
    chk("t4_rd_addr", 64'(mem_addr), 64'h300);
    mem_stb = 1'b1; mem_rdata = 64'h55;
    tick();
    mem_stb = 1'b0; mem_rdata = '0;
    chk("t4_rvalid", 64'(l2_rvalid), 64'd1);
    chk("t4_rdata", l2_rdata, 64'h55);
    chk("t4_unstall", 64'(l2_stall), 64'd0);
    serveWrite("t4_w1", 32'h404, 64'h2);
    // asynchronous reset in the middle of a write
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(i), 64'h50 + 64'(i));
    chk("t5_busy", 64'(mem_req), 64'd1);
    chk("t5_count3", 64'(dut.store.count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_req", 64'(mem_req), 64'd0);
    chk("t5_async_count", 64'(dut.store.count), 64'd0);
    tick();
    rst_n = 1'b1;
    mem_stb = 1'b1;
    tick();
    mem_stb = 1'b0;
    tick();
    chk("t5_stray_req", 64'(mem_req), 64'd0);
    chk("t5_rvalid", 64'(l2_rvalid), 64'd0);
    chk("t5_stall", 64'(l2_stall), 64'd0);
    chk("t5_addr", 64'(mem_addr), 64'd0);
    chk("t5_wdata", mem_wdata, 64'd0);
    chk("t5_count", 64'(dut.store.count), 64'd0);
    // wrap-around with random memory latency
    wrAddrQ.delete();
    wrDataQ.delete();
    for (int c = 0; c < 400 && (sent < 10 || dut.store.count != 0 || mem_req); c++) begin
      l2_we = sent < 10 && !l2_stall;
      l2_addr = 32'h1000 + 32'(sent * 8);
      l2_wdata = 64'hC0 + 64'(sent);
      mem_stb = mem_req && ($urandom_range(0, 2) == 0);
      tick();
      if (l2_we) sent++;
    end
    l2_we = 1'b0; mem_stb = 1'b0;
    chk("t6_n", 64'(wrAddrQ.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      if (i < wrAddrQ.size()) begin
        chk("t6_addr", 64'(wrAddrQ[i]), 64'h1000 + 64'(i * 8));
        chk("t6_data", wrDataQ[i], 64'hC0 + 64'(i));
      end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
